keypad_scanner: RTL

- Active driving end of the 4x4 keypad interface. Walks a single 0 across the row lines and samples the active-low column lines.
- Debounces press and release, and reports one encoded key (code = row*4 + col) with a press strobe and an active-low key-present flag.
- Sits between the keypad pins and the lock controller FSM, which consumes key_valid and key_code.

---
 rtl/keypad_scanner_if.sv | 25 ++
 rtl/keypad_scanner.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-report bundle between the scanner,
// the keypad matrix and the lock controller.
interface keypad_scanner_if;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       kp_bar;

    modport master (
        input  col_in,
        output row_out,
        output key_code,
        output key_valid,
        output kp_bar
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_code,
        input  key_valid,
        input  kp_bar
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with column synchronizer, press/release
// debounce and a one-cycle key strobe carrying row*4+col.
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DEBOUNCE_P = 2'd1,
        PRESSED    = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DEB         = 4'(DEBOUNCE_SCANS);

    state_t     state_q, state_d;
    logic [3:0] sync1_q, sync2_q;
    logic [7:0] settle_q, settle_d;
    logic [1:0] row_q, row_d;
    logic [3:0] row_out_q, row_out_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       kp_bar_q, kp_bar_d;

    logic       tick;
    logic       low_any;
    logic [1:0] pcol;
    logic [3:0] cnt_inc;

    always_comb begin
        low_any = (sync2_q != 4'hF);
        // Lowest low column wins
        if (!sync2_q[0])      pcol = 2'd0;
        else if (!sync2_q[1]) pcol = 2'd1;
        else if (!sync2_q[2]) pcol = 2'd2;
        else                  pcol = 2'd3;

        tick    = (settle_q == SETTLE_LAST);
        cnt_inc = cnt_q + 4'd1;

        state_d     = state_q;
        row_d       = row_q;
        row_out_d   = row_out_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        kp_bar_d    = kp_bar_q;
        settle_d    = tick ? 8'd0 : settle_q + 8'd1;

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (!low_any) begin
                        row_d     = row_q + 2'd1;
                        row_out_d = {row_out_q[2:0], row_out_q[3]};
                    end else begin
                        cand_d = {row_q, pcol};
                        if (DEB == 4'd1) begin
                            state_d     = PRESSED;
                            key_code_d  = {row_q, pcol};
                            key_valid_d = 1'b1;
                            kp_bar_d    = 1'b0;
                            cnt_d       = 4'd0;
                        end else begin
                            state_d = DEBOUNCE_P;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                DEBOUNCE_P: begin
                    if (low_any && pcol == cand_q[1:0]) begin
                        if (cnt_inc == DEB) begin
                            state_d     = PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            kp_bar_d    = 1'b0;
                            cnt_d       = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = SCAN;
                        cnt_d   = 4'd0;
                    end
                end
                PRESSED: begin
                    if (!low_any) begin
                        if (cnt_inc == DEB) begin
                            state_d   = SCAN;
                            kp_bar_d  = 1'b1;
                            cnt_d     = 4'd0;
                            row_d     = row_q + 2'd1;
                            row_out_d = {row_out_q[2:0], row_out_q[3]};
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            settle_q    <= 8'd0;
            row_q       <= 2'd0;
            row_out_q   <= 4'b1110;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            kp_bar_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync1_q     <= kp.col_in;
            sync2_q     <= sync1_q;
            settle_q    <= settle_d;
            row_q       <= row_d;
            row_out_q   <= row_out_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            kp_bar_q    <= kp_bar_d;
        end
    end

    assign kp.row_out   = row_out_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.kp_bar    = kp_bar_q;

endmodule
